qif_tdm_scheduler: RTL and testbench
====================================

QIF_TDM_SCHEDULER -- requirements
Module: qif_tdm_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_NEURONS, 4, number of time-multiplexed neurons (2..64); THRESH, 50, signed 8-bit spike threshold; V_RESET, -20, signed 8-bit post-spike membrane value.
REQ-002 IW SHALL equal max(1, clog2(NUM_NEURONS)).
REQ-003 Ports SHALL be:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- tick_start  in  1  starts one update pass over all neurons.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at pass end.
- cur_req  out  1  synaptic current request.
- cur_idx  out  IW  neuron whose current is requested.
- cur_valid  in  1  cur_data valid for cur_idx.
- cur_data  in  8  signed synaptic current I.
- spk_valid  out  1  spike event valid.
- spk_idx  out  IW  spiking neuron index.
- spk_ready  in  1  spike consumer accepts.
- v_wr_en  in  1  debug membrane write.
- v_wr_idx  in  IW  debug write index.
- v_wr_data  in  8  signed debug write value.
- v_rd_idx  in  IW  monitor read index.
- v_rd_data  out  8  signed V[v_rd_idx], combinational.

Function
REQ-004 The block SHALL hold NUM_NEURONS signed 8-bit membrane registers V[0..N-1] and share one QIF update datapath among them.
REQ-005 FSM states SHALL be IDLE, FETCH, UPDATE, EMIT, DONE.
REQ-006 IDLE: tick_start=1 SHALL set idx=0 and go to FETCH; otherwise stay.
REQ-007 FETCH: cur_req=1 and cur_idx=idx; when cur_valid=1 in the same cycle, cur_data SHALL be captured and the FSM SHALL go to UPDATE; otherwise it waits indefinitely.
REQ-008 UPDATE, one cycle: if V[idx] >= THRESH (signed), V[idx] SHALL be written with V_RESET and the FSM SHALL go to EMIT; otherwise V[idx] SHALL be written with the arithmetic result of REQ-009 and the FSM SHALL advance.
REQ-009 Arithmetic SHALL be V + I/4 + (V/8)*(V/8), with signed division truncating toward zero and computed at >=11-bit signed width; the 8-bit result SHALL be wrapped (two's complement) unless QIF_SAT_EN is defined (REQ-017).
REQ-010 EMIT: spk_valid=1, spk_idx=idx, both held stable until spk_ready=1; the transfer SHALL complete on the cycle with spk_valid and spk_ready both high, then the FSM SHALL advance.
REQ-011 Advance SHALL mean: if idx==NUM_NEURONS-1 go to DONE, else idx+1 and go to FETCH.
REQ-012 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-013 busy SHALL be 1 in FETCH, UPDATE, EMIT and DONE.
REQ-014 tick_start SHALL be ignored whenever busy=1.
REQ-015 v_wr_en SHALL write V[v_wr_idx]=v_wr_data only in IDLE with tick_start=0; it SHALL be ignored otherwise, and v_wr_idx >= NUM_NEURONS SHALL be ignored.
REQ-016 With cur_valid tied high and no spikes, done SHALL assert 2*NUM_NEURONS+1 cycles after the tick_start sampling edge.

Configuration
REQ-017 With macro QIF_SAT_EN defined, the REQ-009 result SHALL saturate to [-128, 127]; without it, the result SHALL wrap modulo 256.

Reset
REQ-018 When rst_n=0 at a clock edge, the block SHALL enter IDLE, set idx=0 and all V=0, and drive busy, done, cur_req and spk_valid to 0 and cur_idx and spk_idx to 0.
REQ-019 A reset during a pass SHALL abort it, including any pending spike, with no done pulse.

Verification
REQ-020 Reset, then sweep v_rd_idx 0..3 -> v_rd_data=0 for all indices, busy=0.
REQ-021 N=4, cur_data=40, cur_valid=1, spk_ready=1, one tick -> every V=10, no spk_valid, done 9 cycles after tick_start.
REQ-022 Debug write V[2]=40, cur_data=0, two ticks -> V[2]=65 after tick 1; tick 2 emits spike spk_idx=2 and sets V[2]=-20.
REQ-023 Debug write V[1]=-128, cur_data=127 -> V[1]=-97 without QIF_SAT_EN, V[1]=127 with it.
REQ-024 V[0]=60, spk_ready=0 for 3 cycles -> spk_valid and spk_idx=0 stable for 4 cycles, busy=1, no FETCH for idx 1 until accepted.
REQ-025 tick_start and v_wr_en pulsed while busy -> no second pass, V unchanged by the write; rst_n=0 mid-pass -> all V=0, no done.

Source files
------------

// File: rtl/qif_tdm_scheduler.sv
// Time-multiplexed quadratic integrate-and-fire scheduler: one shared update datapath
// walks N membrane registers per tick. Define QIF_SAT_EN to saturate instead of wrap.
module qif_tdm_scheduler #(
  parameter int               NUM_NEURONS = 4,
  parameter logic signed [7:0] THRESH     = 8'sd50,
  parameter logic signed [7:0] V_RESET    = -8'sd20,
  localparam int              IW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_start,
  output logic                 busy,
  output logic                 done,
  output logic                 cur_req,
  output logic [IW-1:0]        cur_idx,
  input  logic                 cur_valid,
  input  logic signed [7:0]    cur_data,
  output logic                 spk_valid,
  output logic [IW-1:0]        spk_idx,
  input  logic                 spk_ready,
  input  logic                 v_wr_en,
  input  logic [IW-1:0]        v_wr_idx,
  input  logic signed [7:0]    v_wr_data,
  input  logic [IW-1:0]        v_rd_idx,
  output logic signed [7:0]    v_rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_UPDATE, S_EMIT, S_DONE} state_t;

  state_t                        r_state, w_state_nxt;
  logic [IW-1:0]                 r_idx, w_idx_nxt;
  logic signed [7:0]             r_cur;
  logic [NUM_NEURONS-1:0][7:0]   w_vals;
  logic signed [7:0]             w_cur_v;
  logic                          w_last, w_spike, w_upd_en, w_dbg_en, w_wr_ok, w_rd_ok;
  logic signed [10:0]            w_v11, w_i11, w_vq, w_sum;
  logic signed [7:0]             w_upd;

  assign w_cur_v  = $signed(w_vals[r_idx]);
  assign w_last   = (r_idx == IW'(NUM_NEURONS - 1));
  assign w_spike  = (w_cur_v >= THRESH);
  assign w_upd_en = (r_state == S_UPDATE);
  assign w_wr_ok  = ({1'b0, v_wr_idx} < (IW+1)'(NUM_NEURONS));
  assign w_rd_ok  = ({1'b0, v_rd_idx} < (IW+1)'(NUM_NEURONS));
  // Debug writes only land while idle and not racing a pass start.
  assign w_dbg_en = (r_state == S_IDLE) && !tick_start && v_wr_en && w_wr_ok;

  // QIF step at 11 bits; signed '/' truncates toward zero.
  assign w_v11 = {{3{w_cur_v[7]}}, w_cur_v};
  assign w_i11 = {{3{r_cur[7]}}, r_cur};
  assign w_vq  = w_v11 / 11'sd8;
  assign w_sum = w_v11 + (w_i11 / 11'sd4) + (w_vq * w_vq);

`ifdef QIF_SAT_EN
  always_comb begin
    w_upd = 8'(w_sum);
    if (w_sum > 11'sd127)       w_upd = 8'sd127;
    else if (w_sum < -11'sd128) w_upd = -8'sd128;
  end
`else
  assign w_upd = 8'(w_sum);
`endif

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_neuron
    logic signed [7:0] r_v;
    always_ff @(posedge clk) begin
      if (!rst_n)                                 r_v <= '0;
      else if (w_upd_en && (r_idx == IW'(g)))     r_v <= w_spike ? V_RESET : w_upd;
      else if (w_dbg_en && (v_wr_idx == IW'(g)))  r_v <= v_wr_data;
    end
    assign w_vals[g] = r_v;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cur   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == S_FETCH && cur_valid) r_cur <= cur_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: if (tick_start) begin
        w_state_nxt = S_FETCH;
        w_idx_nxt   = '0;
      end
      S_FETCH: if (cur_valid) w_state_nxt = S_UPDATE;
      S_UPDATE: begin
        if (w_spike)     w_state_nxt = S_EMIT;
        else if (w_last) w_state_nxt = S_DONE;
        else begin
          w_state_nxt = S_FETCH;
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      S_EMIT: if (spk_ready) begin
        if (w_last) w_state_nxt = S_DONE;
        else begin
          w_state_nxt = S_FETCH;
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign cur_req   = (r_state == S_FETCH);
  assign cur_idx   = r_idx;
  assign spk_valid = (r_state == S_EMIT);
  assign spk_idx   = r_idx;
  assign v_rd_data = w_rd_ok ? $signed(w_vals[v_rd_idx]) : 8'sd0;

endmodule

// File: tb/tb_qif_tdm_scheduler.sv
// Bench for qif_tdm_scheduler: per-cycle pass model plus directed literal checks.
module tb_qif_tdm_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int P_IDLE = 0, P_FETCH = 1, P_UPDATE = 2, P_EMIT = 3, P_DONE = 4;

  logic clk = 1'b0, rst_n = 1'b0, tick_start = 1'b0, cur_valid = 1'b0;
  logic spk_ready = 1'b0, v_wr_en = 1'b0;
  logic signed [7:0] cur_data = '0, v_wr_data = '0;
  logic [IW-1:0] v_wr_idx = '0, v_rd_idx = '0;
  logic busy, done, cur_req, spk_valid;
  logic [IW-1:0] cur_idx, spk_idx;
  logic signed [7:0] v_rd_data;

  int nerr = 0, nchk = 0;

  qif_tdm_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick_start(tick_start), .busy(busy), .done(done),
    .cur_req(cur_req), .cur_idx(cur_idx), .cur_valid(cur_valid), .cur_data(cur_data),
    .spk_valid(spk_valid), .spk_idx(spk_idx), .spk_ready(spk_ready),
    .v_wr_en(v_wr_en), .v_wr_idx(v_wr_idx), .v_wr_data(v_wr_data),
    .v_rd_idx(v_rd_idx), .v_rd_data(v_rd_data)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Membrane rule in plain integer arithmetic.
  function automatic int qif(input int v, input int i);
    int r;
    r = v + i / 4 + (v / 8) * (v / 8);
`ifdef QIF_SAT_EN
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`else
    r = (((r + 128) % 256) + 256) % 256 - 128;
`endif
    return r;
  endfunction

  int mv[N];
  int ph = P_IDLE, mi = 0, mcur = 0;

  // Check the cycle just observed, then apply what the coming edge does.
  always @(negedge clk) begin
    chk("busy", int'(busy), int'(ph != P_IDLE));
    chk("done", int'(done), int'(ph == P_DONE));
    chk("cur_req", int'(cur_req), int'(ph == P_FETCH));
    chk("spk_valid", int'(spk_valid), int'(ph == P_EMIT));
    if (ph == P_FETCH) chk("cur_idx", int'(cur_idx), mi);
    if (ph == P_EMIT)  chk("spk_idx", int'(spk_idx), mi);
    chk("v_rd_data", int'(v_rd_data), mv[v_rd_idx]);
    if (!rst_n) begin
      foreach (mv[k]) mv[k] = 0;
      ph = P_IDLE;
      mi = 0;
    end else begin
      case (ph)
        P_IDLE: begin
          if (tick_start) begin ph = P_FETCH; mi = 0; end
          else if (v_wr_en) mv[v_wr_idx] = int'(v_wr_data);
        end
        P_FETCH: if (cur_valid) begin mcur = int'(cur_data); ph = P_UPDATE; end
        P_UPDATE: begin
          if (mv[mi] >= 50) begin mv[mi] = -20; ph = P_EMIT; end
          else begin
            mv[mi] = qif(mv[mi], mcur);
            if (mi == N - 1) ph = P_DONE; else begin mi++; ph = P_FETCH; end
          end
        end
        P_EMIT: if (spk_ready) begin
          if (mi == N - 1) ph = P_DONE; else begin mi++; ph = P_FETCH; end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic clk_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clk_step(); clk_step(); rst_n = 1'b1;
  endtask

  task automatic wr(input int i, input int d);
    v_wr_en = 1'b1; v_wr_idx = IW'(i); v_wr_data = 8'(d);
    clk_step();
    v_wr_en = 1'b0;
  endtask

  task automatic rd(input int i, output int v);
    v_rd_idx = IW'(i); #1; v = int'(v_rd_data);
  endtask

  // Cycles counted from the tick_start sampling edge to the done cycle.
  task automatic tick_wait(output int cyc, output int nspk, output int lastspk);
    tick_start = 1'b1; clk_step(); tick_start = 1'b0;
    cyc = 0; nspk = 0; lastspk = -1;
    do begin
      @(negedge clk); cyc++;
      if (spk_valid && spk_ready) begin nspk++; lastspk = int'(spk_idx); end
    end while (!done && cyc < 200);
    clk_step();
  endtask

  initial begin
    int v, cyc, nspk, lsp, stable, ndone;
    do_reset();

    // reset state
    for (int i = 0; i < N; i++) begin rd(i, v); chk("rst_v", v, 0); end
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur_idx", int'(cur_idx), 0);

    // uniform drive, no spikes
    cur_data = 8'sd40; cur_valid = 1'b1; spk_ready = 1'b1;
    tick_wait(cyc, nspk, lsp);
    chk("lat_plain", cyc, 9);
    chk("nspk_plain", nspk, 0);
    for (int i = 0; i < N; i++) begin rd(i, v); chk("v_after_40", v, 10); end

    // quadratic growth then spike
    do_reset(); wr(2, 40); cur_data = 8'sd0;
    tick_wait(cyc, nspk, lsp);
    chk("lat_t1", cyc, 9);
    rd(2, v); chk("v2_t1", v, 65);
    rd(0, v); chk("v0_t1", v, 0);
    tick_wait(cyc, nspk, lsp);
    chk("lat_t2", cyc, 10);
    chk("nspk_t2", nspk, 1);
    chk("spk_idx_t2", lsp, 2);
    rd(2, v); chk("v2_t2", v, -20);

    // overflow handling
    do_reset(); wr(1, -128); cur_data = 8'sd127;
    tick_wait(cyc, nspk, lsp);
    chk("lat_ovf", cyc, 9);
`ifdef QIF_SAT_EN
    rd(1, v); chk("v1_ovf", v, 127);
`else
    rd(1, v); chk("v1_ovf", v, -97);
`endif
    rd(0, v); chk("v0_127", v, 31);

    // spike back-pressure
    do_reset(); wr(0, 60); cur_data = 8'sd0; spk_ready = 1'b0;
    tick_start = 1'b1; clk_step(); tick_start = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!spk_valid && cyc < 50);
    chk("spk_first", cyc, 3);
    stable = (spk_valid && spk_idx == 0 && busy && !cur_req) ? 1 : 0;
    repeat (2) begin
      @(negedge clk);
      if (spk_valid && spk_idx == 0 && busy && !cur_req) stable++;
    end
    clk_step(); spk_ready = 1'b1;
    @(negedge clk);
    if (spk_valid && spk_idx == 0 && busy && !cur_req) stable++;
    chk("spk_stable", stable, 4);
    @(negedge clk);
    chk("post_spk_valid", int'(spk_valid), 0);
    chk("post_spk_req", int'(cur_req), 1);
    chk("post_spk_idx", int'(cur_idx), 1);
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    chk("bp_done_seen", int'(done), 1);
    clk_step();
    rd(0, v); chk("v0_bp", v, -20);

    // tick/write while busy
    do_reset();
    tick_start = 1'b1; clk_step();
    v_wr_en = 1'b1; v_wr_idx = 2'd3; v_wr_data = 8'sd99;
    repeat (3) clk_step();
    tick_start = 1'b0; v_wr_en = 1'b0;
    cyc = 3;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 200);
    chk("lat_busy_poke", cyc, 9);
    clk_step();
    ndone = 0;
    repeat (6) begin @(negedge clk); if (busy || done) ndone++; end
    chk("no_second_pass", ndone, 0);
    clk_step();
    rd(3, v); chk("v3_unwritten", v, 0);

    // reset mid-pass
    wr(0, 5); wr(3, -7);
    rd(3, v); chk("v3_pre_abort", v, -7);
    tick_start = 1'b1; clk_step(); tick_start = 1'b0;
    repeat (3) clk_step();
    rst_n = 1'b0; clk_step(); rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done) ndone++; end
    chk("abort_no_done", ndone, 0);
    clk_step();
    for (int i = 0; i < N; i++) begin rd(i, v); chk("abort_v", v, 0); end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
